// File: rtl/fb_uart_dump_pkg.sv
// Shared definitions for the framebuffer UART dumper.
// Holds the FSM state encoding, frame header bytes, framebuffer size and the
// bit-period helper. The trailer state only exists when FB_DUMP_CHECKSUM_EN
// is defined.
package fb_uart_dump_pkg;

    localparam int unsigned FB_BYTES        = 256;
    localparam int unsigned UART_FRAME_BITS = 10;   // start + 8 data + stop
    localparam logic [7:0]  HDR_BYTE0       = 8'hA5;
    localparam logic [7:0]  HDR_BYTE1       = 8'h5A;

`ifdef FB_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHdr, StFetch, StWait, StSend, StTail} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHdr, StFetch, StWait, StSend} state_e;
`endif

    // Truncated clocks per bit, never below 2.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return ((clk_hz / baud) < 2) ? 2 : (clk_hz / baud);
    endfunction

endpackage

// File: rtl/fb_uart_dump_uart_tx_core.sv
// uart_tx_core: 8N1 serialiser, LSB first, idle high.
// Ports: clk, rst (async, active-high), data[7:0] byte to send, start (load
// data, honoured only while ready), tx serial line, ready (may accept start).
// ready is also high during the final cycle of the stop bit so a following
// byte starts with no idle gap and the caller can see the exact stop-bit end.
module uart_tx_core
    import fb_uart_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned     CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LAST_BIT = 4'(UART_FRAME_BITS - 1);

    logic          active_q, active_d;
    logic          tx_q, tx_d;
    logic [8:0]    shift_q, shift_d;     // remaining data bits then stop bit
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          last_cycle;

    assign last_cycle = active_q && (bit_cnt_q == LAST_BIT) && (baud_cnt_q == BAUD_MAX);
    assign ready      = !active_q || last_cycle;
    assign tx         = tx_q;

    always_comb begin
        active_d   = active_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (start && ready) begin
            active_d   = 1'b1;
            tx_d       = 1'b0;
            shift_d    = {1'b1, data};
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (active_q) begin
            if (baud_cnt_q == BAUD_MAX) begin
                baud_cnt_d = '0;
                if (bit_cnt_q == LAST_BIT) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_cnt_d = baud_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            tx_q       <= 1'b1;
            shift_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            active_q   <= active_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/fb_uart_dump.sv
// fb_uart_dump: on frame_start, streams a 64x32 1bpp framebuffer over UART as
// header A5 5A, then bytes 0..255 read through fb_addr/fb_data (1-cycle read
// latency). With FB_DUMP_CHECKSUM_EN defined a mod-256 payload sum follows.
// Ports: clk, rst (async, active-high), frame_start (request pulse),
// fb_addr[7:0] (read address, 0 when idle), fb_data[7:0] (read data),
// busy (frame in progress), uart_tx (8N1 serial out).
module fb_uart_dump
    import fb_uart_dump_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    output logic [7:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       busy,
    output logic       uart_tx
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [7:0]  LAST_ADDR    = 8'(FB_BYTES - 1);

    state_e     state_q, state_d;
    logic       busy_q, busy_d;
    logic [7:0] fb_addr_q, fb_addr_d;
    logic [7:0] data_q, data_d;
    logic       hdr_sel_q, hdr_sel_d;    // 0: first header byte, 1: second
    logic       launched_q, launched_d;  // current byte handed to the serialiser
`ifdef FB_DUMP_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       sending;
    logic       byte_done;

    assign busy    = busy_q;
    assign fb_addr = fb_addr_q;

`ifdef FB_DUMP_CHECKSUM_EN
    assign sending = (state_q == StHdr) || (state_q == StSend) || (state_q == StTail);
`else
    assign sending = (state_q == StHdr) || (state_q == StSend);
`endif
    assign tx_start  = sending && !launched_q && tx_ready;
    // ready after launch is only seen in the last stop-bit cycle.
    assign byte_done = launched_q && tx_ready;

    always_comb begin
        tx_data = data_q;
        if (state_q == StHdr) begin
            tx_data = hdr_sel_q ? HDR_BYTE1 : HDR_BYTE0;
        end
`ifdef FB_DUMP_CHECKSUM_EN
        if (state_q == StTail) begin
            tx_data = csum_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        fb_addr_d  = fb_addr_q;
        data_d     = data_q;
        hdr_sel_d  = hdr_sel_q;
        launched_d = launched_q;
`ifdef FB_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (tx_start) begin
            launched_d = 1'b1;
        end else if (byte_done) begin
            launched_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d   = StHdr;
                    busy_d    = 1'b1;
                    hdr_sel_d = 1'b0;
                    fb_addr_d = '0;
`ifdef FB_DUMP_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            StHdr: begin
                if (byte_done) begin
                    if (hdr_sel_q) begin
                        state_d = StFetch;
                    end else begin
                        hdr_sel_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                data_d  = fb_data;
`ifdef FB_DUMP_CHECKSUM_EN
                csum_d  = csum_q + fb_data;
`endif
                state_d = StSend;
            end
            StSend: begin
                if (byte_done) begin
                    if (fb_addr_q == LAST_ADDR) begin
                        // Terminate on wrap rather than start a second pass.
                        fb_addr_d = '0;
`ifdef FB_DUMP_CHECKSUM_EN
                        state_d   = StTail;
`else
                        state_d   = StIdle;
                        busy_d    = 1'b0;
`endif
                    end else begin
                        fb_addr_d = fb_addr_q + 8'd1;
                        state_d   = StFetch;
                    end
                end
            end
`ifdef FB_DUMP_CHECKSUM_EN
            StTail: begin
                if (byte_done) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            fb_addr_q  <= '0;
            data_q     <= '0;
            hdr_sel_q  <= 1'b0;
            launched_q <= 1'b0;
`ifdef FB_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            fb_addr_q  <= fb_addr_d;
            data_q     <= data_d;
            hdr_sel_q  <= hdr_sel_d;
            launched_q <= launched_d;
`ifdef FB_DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .data (tx_data),
        .start(tx_start),
        .tx   (uart_tx),
        .ready(tx_ready)
    );

endmodule
